// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, status bit positions and exception codes shared by the CSR unit and the decoder.
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MEIP     = 11;
    // MPP is hardwired to machine mode, so these bits always read as set
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam logic [31:0] MCAUSE_MEI    = 32'h8000_000B;
    typedef enum logic [30:0] {
        EXC_INSTR_MISALIGNED = 31'd0,
        EXC_ILLEGAL_INSTR    = 31'd2,
        EXC_BREAKPOINT       = 31'd3,
        EXC_LOAD_MISALIGNED  = 31'd4,
        EXC_STORE_MISALIGNED = 31'd6,
        EXC_ECALL_M          = 31'd11
    } exc_code_e;
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit free-running counter with per-half CSR write; only built with CSR_COUNTERS_EN.
`ifdef CSR_COUNTERS_EN
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wd_i,
    output logic [63:0] cnt_o
);
    logic [31:0] lo_q, lo_d, hi_q, hi_d;
    logic        carry;
    // a written half takes the new value; the other half still sees the carry
    always_comb begin
        carry = inc_i & (&lo_q);
        lo_d  = wr_lo_i ? wd_i : lo_q + {31'b0, inc_i};
        hi_d  = wr_hi_i ? wd_i : hi_q + {31'b0, carry};
    end
    // counter state, cleared while reset is low
    always_ff @(posedge clk) begin
        if (!reset) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end
    assign cnt_o = {hi_q, lo_q};
endmodule
`endif

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap/MRET redirect; CSR_COUNTERS_EN adds mcycle/minstret.
module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instrValid,
    input  logic [31:0] pc,
    input  logic        csrAcc,
    input  logic        csrWr,
    input  logic [11:0] csrAddr,
    input  logic [31:0] csrWrData,
    output logic [31:0] csrRdData,
    output logic        illegalCsr,
    input  logic        exception,
    input  logic [30:0] excCode,
    input  logic        mret,
    input  logic        extIrq,
    output logic        trapTaken,
    output logic [31:0] trapPC
);
    import csr_pkg::*;
    logic [1:0]  sync_q, sync_d;
    logic        mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d;
    logic [29:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [31:0] mscratch_q, mscratch_d, mcause_q, mcause_d;
    logic        meip, irq_take, trap, mret_take, known, read_only, wr_en;
    logic        wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
    logic        unused_pc;
    assign unused_pc = ^pc[1:0];
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;
    csr_counter64 u_mcycle (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (1'b1),
        .wr_lo_i (wr_en & (csrAddr == CSR_MCYCLE)),
        .wr_hi_i (wr_en & (csrAddr == CSR_MCYCLEH)),
        .wd_i    (csrWrData),
        .cnt_o   (mcycle)
    );
    csr_counter64 u_minstret (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (instrValid & ~trapTaken),
        .wr_lo_i (wr_en & (csrAddr == CSR_MINSTRET)),
        .wr_hi_i (wr_en & (csrAddr == CSR_MINSTRETH)),
        .wd_i    (csrWrData),
        .cnt_o   (minstret)
    );
`endif
    // address decode: read mux, known-address and read-only flags
    always_comb begin
        csrRdData = '0;
        known     = 1'b1;
        read_only = 1'b0;
        case (csrAddr)
            CSR_MSTATUS: begin
                csrRdData               = MSTATUS_FIXED;
                csrRdData[MSTATUS_MIE]  = mie_q;
                csrRdData[MSTATUS_MPIE] = mpie_q;
            end
            CSR_MIE:      csrRdData[MIE_MEIE] = meie_q;
            CSR_MTVEC:    csrRdData = {mtvec_q, 2'b00};
            CSR_MSCRATCH: csrRdData = mscratch_q;
            CSR_MEPC:     csrRdData = {mepc_q, 2'b00};
            CSR_MCAUSE:   csrRdData = mcause_q;
            CSR_MIP: begin
                csrRdData[MIP_MEIP] = meip;
                read_only           = 1'b1;
            end
            CSR_MHARTID: begin
                csrRdData = HART_ID;
                read_only = 1'b1;
            end
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    csrRdData = mcycle[31:0];
            CSR_MCYCLEH:   csrRdData = mcycle[63:32];
            CSR_MINSTRET:  csrRdData = minstret[31:0];
            CSR_MINSTRETH: csrRdData = minstret[63:32];
            CSR_CYCLE: begin
                csrRdData = mcycle[31:0];
                read_only = 1'b1;
            end
            CSR_CYCLEH: begin
                csrRdData = mcycle[63:32];
                read_only = 1'b1;
            end
            CSR_INSTRET: begin
                csrRdData = minstret[31:0];
                read_only = 1'b1;
            end
            CSR_INSTRETH: begin
                csrRdData = minstret[63:32];
                read_only = 1'b1;
            end
`endif
            default: known = 1'b0;
        endcase
    end
    assign illegalCsr  = ((csrAcc | csrWr) & ~known) | (csrWr & read_only);
    assign meip        = sync_q[1];
    assign irq_take    = instrValid & mie_q & meie_q & meip;
    assign trap        = reset & ((instrValid & exception) | irq_take);
    assign mret_take   = reset & instrValid & mret & ~trap;
    assign trapTaken   = trap | mret_take;
    assign trapPC      = trap ? {mtvec_q, 2'b00} : mret_take ? {mepc_q, 2'b00} : '0;
    assign wr_en       = instrValid & csrWr & ~trapTaken & ~illegalCsr;
    assign wr_mstatus  = wr_en & (csrAddr == CSR_MSTATUS);
    assign wr_mie      = wr_en & (csrAddr == CSR_MIE);
    assign wr_mtvec    = wr_en & (csrAddr == CSR_MTVEC);
    assign wr_mscratch = wr_en & (csrAddr == CSR_MSCRATCH);
    assign wr_mepc     = wr_en & (csrAddr == CSR_MEPC);
    assign wr_mcause   = wr_en & (csrAddr == CSR_MCAUSE);
    // next state: trap beats MRET beats CSR write
    always_comb begin
        sync_d     = {sync_q[0], extIrq};
        mie_d      = trap ? 1'b0 : mret_take ? mpie_q : wr_mstatus ? csrWrData[MSTATUS_MIE] : mie_q;
        mpie_d     = trap ? mie_q : mret_take ? 1'b1 : wr_mstatus ? csrWrData[MSTATUS_MPIE] : mpie_q;
        meie_d     = wr_mie ? csrWrData[MIE_MEIE] : meie_q;
        mtvec_d    = wr_mtvec ? csrWrData[31:2] : mtvec_q;
        mscratch_d = wr_mscratch ? csrWrData : mscratch_q;
        mepc_d     = trap ? pc[31:2] : wr_mepc ? csrWrData[31:2] : mepc_q;
        mcause_d   = trap ? (exception ? {1'b0, excCode} : MCAUSE_MEI) : wr_mcause ? csrWrData : mcause_q;
    end
    // CSR and synchronizer registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q     <= '0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET[31:2];
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            sync_q     <= sync_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed self-checking bench for csr_trap_unit.
module tb_csr_trap_unit;
    logic        clk = 1'b0;
    logic        reset, instrValid, csrAcc, csrWr, exception, mret, extIrq;
    logic [31:0] pc, csrWrData, csrRdData, trapPC;
    logic [11:0] csrAddr;
    logic [30:0] excCode;
    logic        illegalCsr, trapTaken;
    logic [31:0] v;
    logic        ill;
    int          n_cmp = 0;
    int          n_err = 0;

    csr_trap_unit #(.MTVEC_RESET(32'h0000_0200), .HART_ID(32'd3)) dut (
        .clk(clk), .reset(reset), .instrValid(instrValid), .pc(pc), .csrAcc(csrAcc), .csrWr(csrWr),
        .csrAddr(csrAddr), .csrWrData(csrWrData), .csrRdData(csrRdData), .illegalCsr(illegalCsr),
        .exception(exception), .excCode(excCode), .mret(mret), .extIrq(extIrq),
        .trapTaken(trapTaken), .trapPC(trapPC)
    );

    always #5 clk = ~clk;

    task automatic idle();
        instrValid = 0; csrAcc = 0; csrWr = 0; exception = 0; mret = 0;
        csrAddr = '0; csrWrData = '0; excCode = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        instrValid = 1; csrAcc = 1; csrWr = 1; csrAddr = a; csrWrData = d;
        step();
        idle();
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] val, output logic il);
        instrValid = 0; csrAcc = 1; csrAddr = a;
        #1;
        val = csrRdData; il = illegalCsr;
        csrAcc = 0;
    endtask

    task automatic test_reset();
        idle(); extIrq = 0; pc = 32'h10; reset = 0;
        instrValid = 1; exception = 1; mret = 1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (trapTaken !== 1'b0) begin n_err++; $display("FAIL rst_trapTaken got=%b exp=0", trapTaken); end
        n_cmp++; if (trapPC !== 32'h0) begin n_err++; $display("FAIL rst_trapPC got=%h exp=0", trapPC); end
        idle(); reset = 1;
        rd(12'h300, v, ill);
        n_cmp++; if (v !== 32'h1800) begin n_err++; $display("FAIL rst_mstatus got=%h exp=00001800", v); end
        rd(12'h305, v, ill);
        n_cmp++; if (v !== 32'h200) begin n_err++; $display("FAIL rst_mtvec got=%h exp=00000200", v); end
        rd(12'h342, v, ill);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_mcause got=%h exp=0", v); end
        rd(12'hF14, v, ill);
        n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL rst_mhartid got=%h exp=3", v); end
    endtask

    task automatic test_exception();
        csr_write(12'h305, 32'h0000_0103);
        rd(12'h305, v, ill);
        n_cmp++; if (v !== 32'h100) begin n_err++; $display("FAIL mtvec_mask got=%h exp=00000100", v); end
        csr_write(12'h300, 32'h8);
        rd(12'h300, v, ill);
        n_cmp++; if (v !== 32'h1808) begin n_err++; $display("FAIL mstatus_wr got=%h exp=00001808", v); end
        instrValid = 1; exception = 1; excCode = 31'd11; pc = 32'h40;
        #1;
        n_cmp++; if (trapTaken !== 1'b1) begin n_err++; $display("FAIL exc_trapTaken got=%b exp=1", trapTaken); end
        n_cmp++; if (trapPC !== 32'h100) begin n_err++; $display("FAIL exc_trapPC got=%h exp=00000100", trapPC); end
        step(); idle();
        rd(12'h341, v, ill);
        n_cmp++; if (v !== 32'h40) begin n_err++; $display("FAIL exc_mepc got=%h exp=00000040", v); end
        rd(12'h342, v, ill);
        n_cmp++; if (v !== 32'd11) begin n_err++; $display("FAIL exc_mcause got=%h exp=0000000b", v); end
        rd(12'h300, v, ill);
        n_cmp++; if (v !== 32'h1880) begin n_err++; $display("FAIL exc_mstatus got=%h exp=00001880", v); end
    endtask

    task automatic test_irq();
        csr_write(12'h304, 32'hFFFF_FFFF);
        rd(12'h304, v, ill);
        n_cmp++; if (v !== 32'h800) begin n_err++; $display("FAIL mie_mask got=%h exp=00000800", v); end
        csr_write(12'h305, 32'h200);
        csr_write(12'h300, 32'h8);
        extIrq = 1; instrValid = 1; pc = 32'h44;
        #1;
        n_cmp++; if (trapTaken !== 1'b0) begin n_err++; $display("FAIL irq_edge0 got=%b exp=0", trapTaken); end
        step(); #1;
        n_cmp++; if (trapTaken !== 1'b0) begin n_err++; $display("FAIL irq_edge1 got=%b exp=0", trapTaken); end
        step();
        csrAcc = 1; csrAddr = 12'h344; #1;
        n_cmp++; if (trapTaken !== 1'b1) begin n_err++; $display("FAIL irq_edge2 got=%b exp=1", trapTaken); end
        n_cmp++; if (trapPC !== 32'h200) begin n_err++; $display("FAIL irq_trapPC got=%h exp=00000200", trapPC); end
        n_cmp++; if (csrRdData !== 32'h800) begin n_err++; $display("FAIL irq_mip got=%h exp=00000800", csrRdData); end
        step(); idle();
        rd(12'h342, v, ill);
        n_cmp++; if (v !== 32'h8000_000B) begin n_err++; $display("FAIL irq_mcause got=%h exp=8000000b", v); end
        rd(12'h341, v, ill);
        n_cmp++; if (v !== 32'h44) begin n_err++; $display("FAIL irq_mepc got=%h exp=00000044", v); end
        instrValid = 1; #1;
        n_cmp++; if (trapTaken !== 1'b0) begin n_err++; $display("FAIL irq_masked got=%b exp=0", trapTaken); end
        idle();
        csr_write(12'h300, 32'h8);
        instrValid = 1; exception = 1; excCode = 31'd2; pc = 32'h48;
        #1;
        n_cmp++; if (trapTaken !== 1'b1) begin n_err++; $display("FAIL both_trap got=%b exp=1", trapTaken); end
        step(); idle(); extIrq = 0;
        rd(12'h342, v, ill);
        n_cmp++; if (v !== 32'd2) begin n_err++; $display("FAIL both_mcause got=%h exp=00000002", v); end
        rd(12'h341, v, ill);
        n_cmp++; if (v !== 32'h48) begin n_err++; $display("FAIL both_mepc got=%h exp=00000048", v); end
        step(); step();
    endtask

    task automatic test_mret();
        mret = 1; instrValid = 0; #1;
        n_cmp++; if (trapTaken !== 1'b0) begin n_err++; $display("FAIL mret_invalid got=%b exp=0", trapTaken); end
        idle();
        csr_write(12'h341, 32'h80);
        instrValid = 1; mret = 1; #1;
        n_cmp++; if (trapTaken !== 1'b1) begin n_err++; $display("FAIL mret_taken got=%b exp=1", trapTaken); end
        n_cmp++; if (trapPC !== 32'h80) begin n_err++; $display("FAIL mret_trapPC got=%h exp=00000080", trapPC); end
        step(); idle();
        rd(12'h300, v, ill);
        n_cmp++; if (v !== 32'h1888) begin n_err++; $display("FAIL mret_mstatus got=%h exp=00001888", v); end
    endtask

    task automatic test_illegal();
        instrValid = 1; csrAcc = 1; csrWr = 1; csrAddr = 12'hF14; csrWrData = 32'h7; #1;
        n_cmp++; if (illegalCsr !== 1'b1) begin n_err++; $display("FAIL ro_illegal got=%b exp=1", illegalCsr); end
        step(); idle();
        rd(12'hF14, v, ill);
        n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL ro_unchanged got=%h exp=3", v); end
        rd(12'h7C0, v, ill);
        n_cmp++; if (ill !== 1'b1) begin n_err++; $display("FAIL unk_illegal got=%b exp=1", ill); end
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL unk_read got=%h exp=0", v); end
        rd(12'h340, v, ill);
        n_cmp++; if (ill !== 1'b0) begin n_err++; $display("FAIL known_legal got=%b exp=0", ill); end
        instrValid = 1; csrAcc = 1; csrWr = 1; csrAddr = 12'h340; csrWrData = 32'hDEAD_BEEF;
        exception = 1; excCode = 31'd2; pc = 32'h50;
        step(); idle();
        rd(12'h340, v, ill);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL exc_blocks_wr got=%h exp=0", v); end
    endtask

    task automatic test_back_to_back();
        instrValid = 1; csrAcc = 1; csrWr = 1; csrAddr = 12'h340; csrWrData = 32'h1234;
        step();
        csrWrData = 32'h5678; #1;
        n_cmp++; if (csrRdData !== 32'h1234) begin n_err++; $display("FAIL raw_old got=%h exp=00001234", csrRdData); end
        step(); idle();
        rd(12'h340, v, ill);
        n_cmp++; if (v !== 32'h5678) begin n_err++; $display("FAIL raw_new got=%h exp=00005678", v); end
        csr_write(12'h341, 32'h0000_0083);
        rd(12'h341, v, ill);
        n_cmp++; if (v !== 32'h80) begin n_err++; $display("FAIL mepc_mask got=%h exp=00000080", v); end
        csr_write(12'h342, 32'h8000_0003);
        rd(12'h342, v, ill);
        n_cmp++; if (v !== 32'h8000_0003) begin n_err++; $display("FAIL mcause_wr got=%h exp=80000003", v); end
    endtask

    task automatic test_counters();
`ifdef CSR_COUNTERS_EN
        csr_write(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00, v, ill);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mcycle_wr got=%h exp=ffffffff", v); end
        rd(12'hB80, v, ill);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL mcycleh_pre got=%h exp=0", v); end
        step();
        rd(12'hB00, v, ill);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL mcycle_wrap got=%h exp=0", v); end
        rd(12'hC80, v, ill);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL cycleh_carry got=%h exp=1", v); end
        instrValid = 1; csrAcc = 1; csrWr = 1; csrAddr = 12'hC00; #1;
        n_cmp++; if (illegalCsr !== 1'b1) begin n_err++; $display("FAIL cycle_ro got=%b exp=1", illegalCsr); end
        idle();
        csr_write(12'hB02, 32'd5);
        rd(12'hB02, v, ill);
        n_cmp++; if (v !== 32'd5) begin n_err++; $display("FAIL minstret_wr got=%h exp=5", v); end
        instrValid = 1; step(); idle();
        rd(12'hB02, v, ill);
        n_cmp++; if (v !== 32'd6) begin n_err++; $display("FAIL minstret_inc got=%h exp=6", v); end
`else
        rd(12'hB00, v, ill);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL nocnt_read got=%h exp=0", v); end
        n_cmp++; if (ill !== 1'b1) begin n_err++; $display("FAIL nocnt_illegal got=%b exp=1", ill); end
`endif
    endtask

    initial begin
        test_reset();
        test_exception();
        test_irq();
        test_mret();
        test_illegal();
        test_back_to_back();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
